// File: rtl/riscv_core_mul_pkg.sv
// Shared definitions for the multiplier operand-conditioning and result stages.
package riscv_core_mul_pkg;

  // Width of the destination tag held in the side-info record.
  localparam int MUL_TAGW = 5;

  // Multiply operation select, shared with the operand-conditioning stage.
  typedef enum logic [1:0] {
    MUL_CTRL_MUL    = 2'b00,  // MUL / MULW
    MUL_CTRL_MULH   = 2'b01,
    MUL_CTRL_MULHSU = 2'b10,
    MUL_CTRL_MULHU  = 2'b11
  } mul_ctrl_e;

  // Information that travels alongside the magnitude product.
  typedef struct packed {
    logic                negate;
    mul_ctrl_e           control;
    logic                isword;
    logic [MUL_TAGW-1:0] tag;
  } mul_sideinfo_t;

  // Whether the magnitude product must be negated to obtain the signed result.
  function automatic logic mul_negate(input logic      a_sign,
                                      input logic      b_sign,
                                      input mul_ctrl_e ctrl,
                                      input logic      isword);
    logic neg;
    neg = 1'b0;
    if (isword) begin
      neg = (ctrl == MUL_CTRL_MUL) ? (a_sign ^ b_sign) : 1'b0;
    end else begin
      case (ctrl)
        MUL_CTRL_MUL,
        MUL_CTRL_MULH:   neg = a_sign ^ b_sign;
        MUL_CTRL_MULHSU: neg = a_sign;
        default:         neg = 1'b0;
      endcase
    end
    return neg;
  endfunction

endpackage

// File: rtl/riscv_core_mul_signfix.sv
// Conditional two's-complement negate of a double-width magnitude, followed by
// low/high half select or word sign-extension. Purely combinational.
module riscv_core_mul_signfix
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_product,
  input  logic              i_negate,
  input  mul_ctrl_e         i_control,
  input  logic              i_isword,
  output logic [XLEN-1:0]   o_result
);

  logic [2*XLEN-1:0] signed_p;

  // Negation wraps mod 2^(2*XLEN), so a zero magnitude stays zero.
  always_comb begin
    signed_p = i_product;
    if (i_negate) begin
      signed_p = ~i_product + (2*XLEN)'(1);
    end
  end

  // Word results sign-extend the low half-word; MUL takes the low half, the
  // MULH family takes the high half.
  always_comb begin
    o_result = signed_p[XLEN-1:0];
    if (i_isword) begin
      o_result = {{(XLEN/2){signed_p[XLEN/2-1]}}, signed_p[XLEN/2-1:0]};
    end else if (i_control != MUL_CTRL_MUL) begin
      o_result = signed_p[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/riscv_core_mul_out.sv
// Multiplier result stage: re-applies sign to the unsigned array product and
// selects the architectural result through a two-stage valid/ready pipeline.
//
// Handshake: a beat transfers on any rising edge where valid and ready are both
// high on that interface. o_mul_out_ready depends only on pipeline state and
// i_mul_out_ready, never on i_mul_out_valid. Once o_mul_out_valid is high, the
// result and tag hold until the beat is taken or the pipeline is flushed/reset.
module riscv_core_mul_out
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = MUL_TAGW   // must equal MUL_TAGW (side-info tag width)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mul_out_valid,
  output logic              o_mul_out_ready,
  input  logic [2*XLEN-1:0] i_mul_out_product,
  input  logic              i_mul_out_srcA_sign,
  input  logic              i_mul_out_srcB_sign,
  input  logic [1:0]        i_mul_out_control,
  input  logic              i_mul_out_isword,
  input  logic [TAGW-1:0]   i_mul_out_tag,
  input  logic              i_mul_out_flush,
  output logic              o_mul_out_valid,
  input  logic              i_mul_out_ready,
  output logic [XLEN-1:0]   o_mul_out_result,
  output logic [TAGW-1:0]   o_mul_out_tag
);

  logic              s1_valid_q, s1_valid_d;
  logic [2*XLEN-1:0] s1_product_q, s1_product_d;
  mul_sideinfo_t     s1_side_q, s1_side_d;

  logic              s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]   s2_result_q, s2_result_d;
  logic [TAGW-1:0]   s2_tag_q, s2_tag_d;

  logic              s1_adv, s2_adv, accept;
  mul_ctrl_e         in_ctrl;
  logic [XLEN-1:0]   fix_result;

  assign in_ctrl = mul_ctrl_e'(i_mul_out_control);

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_adv = !s2_valid_q | i_mul_out_ready;
  assign s1_adv = !s1_valid_q | s2_adv;
  assign accept = i_mul_out_valid & s1_adv;

  assign o_mul_out_ready  = s1_adv;
  assign o_mul_out_valid  = s2_valid_q;
  assign o_mul_out_result = s2_result_q;
  assign o_mul_out_tag    = s2_tag_q;

  riscv_core_mul_signfix #(
    .XLEN(XLEN)
  ) u_signfix (
    .i_product (s1_product_q),
    .i_negate  (s1_side_q.negate),
    .i_control (s1_side_q.control),
    .i_isword  (s1_side_q.isword),
    .o_result  (fix_result)
  );

  // Next-state for both stages; flush overrides acceptance and advance.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_product_d = s1_product_q;
    s1_side_d    = s1_side_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    if (i_mul_out_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_result_d = fix_result;
          s2_tag_d    = TAGW'(s1_side_q.tag);
        end
      end
      if (s1_adv) begin
        s1_valid_d = i_mul_out_valid;
        if (accept) begin
          s1_product_d     = i_mul_out_product;
          s1_side_d.negate = mul_negate(i_mul_out_srcA_sign, i_mul_out_srcB_sign,
                                        in_ctrl, i_mul_out_isword);
          s1_side_d.control = in_ctrl;
          s1_side_d.isword  = i_mul_out_isword;
          s1_side_d.tag     = MUL_TAGW'(i_mul_out_tag);
        end
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_product_q <= '0;
      s1_side_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_product_q <= s1_product_d;
      s1_side_q    <= s1_side_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_mul_out.sv
// Bench for riscv_core_mul_out: vector table, scoreboard queue, and directed
// stall / flush / reset sequences.
module tb_riscv_core_mul_out;
  import riscv_core_mul_pkg::*;

  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam int NVEC = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [2*XLEN-1:0] i_product;
  logic              i_sa;
  logic              i_sb;
  logic [1:0]        i_ctrl;
  logic              i_isword;
  logic [TAGW-1:0]   i_tag;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_result;
  logic [TAGW-1:0]   o_tag;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  riscv_core_mul_out #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_mul_out_valid     (i_valid),
    .o_mul_out_ready     (o_ready),
    .i_mul_out_product   (i_product),
    .i_mul_out_srcA_sign (i_sa),
    .i_mul_out_srcB_sign (i_sb),
    .i_mul_out_control   (i_ctrl),
    .i_mul_out_isword    (i_isword),
    .i_mul_out_tag       (i_tag),
    .i_mul_out_flush     (i_flush),
    .o_mul_out_valid     (o_valid),
    .i_mul_out_ready     (i_ready),
    .o_mul_out_result    (o_result),
    .o_mul_out_tag       (o_tag)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2*XLEN-1:0] product;
    logic              sa;
    logic              sb;
    logic [1:0]        ctrl;
    logic              isword;
    logic [XLEN-1:0]   exp;
  } vec_t;

  vec_t vecs[NVEC];

  logic [TAGW+XLEN-1:0] exp_q[$];
  logic [TAGW+XLEN-1:0] drv_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input int idx, input logic [TAGW-1:0] tag);
    i_valid   = 1'b1;
    i_product = vecs[idx].product;
    i_sa      = vecs[idx].sa;
    i_sb      = vecs[idx].sb;
    i_ctrl    = vecs[idx].ctrl;
    i_isword  = vecs[idx].isword;
    i_tag     = tag;
    drv_exp   = {tag, vecs[idx].exp};
  endtask

  // Offers one beat and holds it until accepted (bounded).
  task automatic send_beat(input int idx, input logic [TAGW-1:0] tag);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    drive_beat(idx, tag);
    do begin
      @(negedge clk);
      acc = o_ready;
      step();
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", tag);
    end
    i_valid = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic            stall_prev;
  logic [XLEN-1:0] res_prev;
  logic [TAGW-1:0] tag_prev;

  always @(negedge clk) begin
    logic [TAGW+XLEN-1:0] e;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      // Ready must drop only when both stages hold a beat and downstream stalls.
      check("ready_vs_occupancy", 64'(o_ready),
            64'(!(exp_q.size() == 2 && !i_ready)));
      if (stall_prev) begin
        check("stall_hold_valid", 64'(o_valid), 64'(1));
        check("stall_hold_result", 64'(o_result), 64'(res_prev));
        check("stall_hold_tag", 64'(o_tag), 64'(tag_prev));
      end
      stall_prev = o_valid && !i_ready;
      res_prev   = o_result;
      tag_prev   = o_tag;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=tag%0d/%h required=no_beat", o_tag, o_result);
        end else begin
          e = exp_q.pop_front();
          check("beat_tag", 64'(o_tag), 64'(e[TAGW+XLEN-1:XLEN]));
          check("beat_result", 64'(o_result), 64'(e[XLEN-1:0]));
        end
      end
      if (i_flush) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else if (i_valid && o_ready) begin
        exp_q.push_back(drv_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit stream_done;

  initial begin
    // {product, srcA_sign, srcB_sign, control, isword, expected result}
    vecs[0]  = '{64'd15,                  1'b0, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFF1}; // MUL 3*-5
    vecs[1]  = '{64'h0000_0000_8000_0000, 1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF}; // MULH -2^31*1
    vecs[2]  = '{64'h0000_0000_8000_0000, 1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0000}; // MUL -2^31*1
    vecs[3]  = '{64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF}; // MULHSU
    vecs[4]  = '{64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0000}; // MULHU
    vecs[5]  = '{64'd15,                  1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFF1}; // MULW -3*5
    vecs[6]  = '{64'd0,                   1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000}; // zero, negate
    vecs[7]  = '{64'd0,                   1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0000}; // zero, negate, high
    vecs[8]  = '{64'h4000_0000_0000_0000, 1'b1, 1'b1, 2'b01, 1'b0, 32'h4000_0000}; // max magnitude
    vecs[9]  = '{64'h4000_0000_0000_0000, 1'b0, 1'b1, 2'b01, 1'b0, 32'hC000_0000}; // max magnitude neg
    vecs[10] = '{64'h0000_0000_0000_8001, 1'b1, 1'b1, 2'b01, 1'b1, 32'hFFFF_8001}; // word, no negate
    vecs[11] = '{64'h0000_0000_1234_5678, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_5678}; // MULW positive
    vecs[12] = '{64'h0000_0001_0000_0000, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0001}; // MULHSU sA=0
    vecs[13] = '{64'h4000_0000_0000_0000, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000}; // max magnitude low

    rst = 1'b1; i_valid = 1'b0; i_product = '0; i_sa = 1'b0; i_sb = 1'b0;
    i_ctrl = 2'b00; i_isword = 1'b0; i_tag = '0; i_flush = 1'b0; i_ready = 1'b1;
    drv_exp = '0; stream_done = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_result", 64'(o_result), 64'(0));
    check("rst_tag", 64'(o_tag), 64'(0));
    check("rst_ready", 64'(o_ready), 64'(1));
    step();

    // Table: one beat at a time, exact two-cycle latency; value via scoreboard.
    for (int i = 0; i < NVEC; i++) begin
      drive_beat(i, TAGW'(i + 1));
      step();
      i_valid = 1'b0;
      @(negedge clk);
      check("lat1_valid", 64'(o_valid), 64'(0));
      step();
      @(negedge clk);
      check("lat2_valid", 64'(o_valid), 64'(1));
      step();
    end

    // Four back-to-back beats, downstream stalled for three cycles.
    fork
      begin
        send_beat(0, 5'd1);
        send_beat(1, 5'd2);
        send_beat(3, 5'd3);
        send_beat(5, 5'd4);
      end
      begin
        repeat (2) step();
        i_ready = 1'b0;
        repeat (3) step();
        i_ready = 1'b1;
      end
    join
    repeat (4) step();
    check("stream_drained", 64'(exp_q.size()), 64'(0));

    // Flush with both stages full and an input offered.
    i_ready = 1'b0;
    drive_beat(0, 5'd10);
    step();
    drive_beat(1, 5'd11);
    step();
    drive_beat(2, 5'd12);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(o_valid), 64'(0));
    i_ready = 1'b1;
    repeat (4) step();
    drive_beat(3, 5'd13);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    check("post_flush_lat1", 64'(o_valid), 64'(0));
    step();
    @(negedge clk);
    check("post_flush_lat2", 64'(o_valid), 64'(1));
    step();

    // Reset in the middle of a stalled, full pipeline.
    i_ready = 1'b0;
    drive_beat(4, 5'd20);
    step();
    drive_beat(6, 5'd21);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(o_valid), 64'(0));
    check("midrst_result", 64'(o_result), 64'(0));
    check("midrst_tag", 64'(o_tag), 64'(0));
    check("midrst_ready", 64'(o_ready), 64'(1));
    i_ready = 1'b1;
    step();

    // Random streaming with random backpressure and gaps.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 3) == 0) step();
          send_beat(int'($urandom_range(0, NVEC - 1)), TAGW'($urandom_range(0, 31)));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          i_ready = ($urandom_range(0, 2) != 0);
          step();
        end
        i_ready = 1'b1;
      end
    join

    // Drain, bounded.
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    step();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_core_mul_out.md
Name: riscv_core_mul_out

Overview:
Result-side counterpart of the multiplier operand-conditioning stage. Operands reach the unsigned multiplier array as magnitudes, and the array returns an unsigned magnitude product. This block takes that product, re-applies the sign, and selects the low or high half (or the word result). It is a 2-stage valid/ready pipeline between the multiplier array and the EX/MEM writeback path, and it carries a destination tag alongside each result.

Parameters:
XLEN, 32, architectural register width; the product is 2*XLEN bits.
TAGW, 5, width of the destination-register tag carried with each result.

Ports:
i_clk  input  1  core clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_mul_out_valid  input  1  product and side info are valid this cycle.
o_mul_out_ready  output  1  block accepts input this cycle.
i_mul_out_product  input  2*XLEN  unsigned magnitude product from the array.
i_mul_out_srcA_sign  input  1  original rs1 sign: bit XLEN-1, or bit XLEN/2-1 when isword.
i_mul_out_srcB_sign  input  1  original rs2 sign: bit XLEN-1, or bit XLEN/2-1 when isword.
i_mul_out_control  input  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU.
i_mul_out_isword  input  1  word operation (operands were XLEN/2 bits).
i_mul_out_tag  input  TAGW  destination tag; passed through unchanged.
i_mul_out_flush  input  1  kill all in-flight results.
o_mul_out_valid  output  1  result valid.
i_mul_out_ready  input  1  downstream accepts result.
o_mul_out_result  output  XLEN  signed-corrected, half-selected result.
o_mul_out_tag  output  TAGW  tag of o_mul_out_result.

Behaviour:
- Reset (i_rst=1 at a clock edge): both stage valids, o_mul_out_valid, o_mul_out_result and o_mul_out_tag go to 0. o_mul_out_ready is 1 in the cycle after reset.
- Negate flag, computed at input:
  - MUL and MULH: srcA_sign ^ srcB_sign.
  - MULHSU: srcA_sign.
  - MULHU: 0.
  - isword with control 00: srcA_sign ^ srcB_sign.
  - isword with any other control: 0.
- Stage 1 (S1) registers: valid, product, negate, control, isword, tag.
- Stage 2 (S2) computation from the S1 registers:
  - signed product P = negate ? (~product + 1) mod 2^(2*XLEN) : product.
  - Non-word MUL: result = P[XLEN-1:0]. MULH, MULHSU, MULHU: result = P[2*XLEN-1:XLEN].
  - Word: result = sign-extension of P[XLEN/2-1:0] to XLEN bits.
- S2 registers the result and tag and drives the outputs directly; there is no combinational path from inputs to outputs.
- Handshake:
  - s2_adv = !s2_valid | i_mul_out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - o_mul_out_ready = s1_adv, with no dependence on i_mul_out_valid.
  - Input is accepted when i_mul_out_valid & o_mul_out_ready.
  - An output beat completes when o_mul_out_valid & i_mul_out_ready.
- Latency: exactly 2 cycles from acceptance to o_mul_out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stall: while i_mul_out_ready=0 and S2 is valid, S2 result, tag and valid hold stable. S1 holds if it is valid; if S1 is empty it may still fill.
- Flush: i_mul_out_flush=1 clears s1_valid and s2_valid at the next edge and drops any input offered that cycle. Flush has priority over acceptance and advance. Data registers may retain stale values, but valid is 0.
- Reset asserted mid-operation behaves identically to flush and also zeroes the data outputs.
- Zero product with negate=1 yields 0, since two's complement of 0 wraps to 0.
- The most-negative magnitude 2^(2*XLEN-2) with negate=0 passes unmodified.
- Simultaneous S2 drain and S1 refill in one cycle is legal and must not drop or duplicate a beat.

Decomposition:
- Shared package riscv_core_mul_pkg holds:
  - a 2-bit mul_ctrl_e enum (MUL/MULW=00, MULH=01, MULHSU=10, MULHU=11), shared with the operand-conditioning stage;
  - a typedef mul_sideinfo_t {negate, control, isword, tag}.
- One natural sub-module, riscv_core_mul_signfix: a combinational 2*XLEN conditional negate plus half/word select. It is instantiated between S1 and S2 and reusable by a future divider result stage.

Test Plan:
- MUL, A=3, B=-5, so magnitudes 3 and 5: product 15, signs A=0, B=1 -> result 0xFFFFFFF1, two cycles after acceptance.
- MULH, A=-2^31, B=1: product 0x00000000_80000000, signs 1,0 -> 0xFFFFFFFF. The same input with MUL -> 0x80000000.
- MULHSU, A=-1, B=0xFFFFFFFF: product 0x00000000_FFFFFFFF, srcA_sign=1 -> 0xFFFFFFFF. MULHU with the same product and both sign bits set -> 0x00000000.
- isword MULW, A=0xFFFD (-3), B=0x0005: product 15, signs 1,0 -> 0xFFFFFFF1.
- Streaming with backpressure: 4 back-to-back beats with tags 1..4 and i_mul_out_ready low for cycles 3-5 -> results emerge in order, S2 is stable while stalled, o_mul_out_ready drops only when both stages are full, no beat is lost or duplicated.
- Flush with both stages full and an input offered -> next cycle o_mul_out_valid=0 and nothing emerges for those beats. The following input emerges normally 2 cycles after acceptance.
